// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the three requesters, the issue logic and the
// register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [2:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [ADDR_W-1:0] req_addr2;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [DATA_W-1:0] req_data2;
  logic [2:0]        req_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_busy;
  logic              init_busy;

  // Arbiter side: consumes requests and issue/query info, drives the write port.
  modport slave (
    input  req_valid, req_addr0, req_addr1, req_addr2,
    input  req_data0, req_data1, req_data2,
    input  iss_valid, iss_addr, chk_addr,
    output req_ready, rf_we, rf_wa, rf_wd, chk_busy, init_busy
  );

  // Requester / issue side.
  modport master (
    output req_valid, req_addr0, req_addr1, req_addr2,
    output req_data0, req_data1, req_data2,
    output iss_valid, iss_addr, chk_addr,
    input  req_ready, rf_we, rf_wa, rf_wd, chk_busy, init_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter owning the register-file write port, with a
// pending-write scoreboard and a post-reset zero-fill sequencer.
module regfile_wb_arbiter #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit ZERO_REG       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_Z   = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [2:0]          grant_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [1:0]          next_ptr_s;
  logic                iss_set_s;

  // First valid requester in the order ptr, ptr+1, ptr+2 (mod 3), one-hot.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] ptr);
    logic [2:0] g;
    g = 3'b000;
    case (ptr)
      2'd0:    g = v[0] ? 3'b001 : (v[1] ? 3'b010 : (v[2] ? 3'b100 : 3'b000));
      2'd1:    g = v[1] ? 3'b010 : (v[2] ? 3'b100 : (v[0] ? 3'b001 : 3'b000));
      2'd2:    g = v[2] ? 3'b100 : (v[0] ? 3'b001 : (v[1] ? 3'b010 : 3'b000));
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  // Pick the winner and steer its address/data; also its successor pointer.
  always_comb begin
    grant_s    = rr_pick(bus.req_valid, rr_ptr_q);
    sel_addr_s = ADDR_Z;
    sel_data_s = {DATA_W{1'b0}};
    next_ptr_s = rr_ptr_q;
    case (grant_s)
      3'b001: begin
        sel_addr_s = bus.req_addr0;
        sel_data_s = bus.req_data0;
        next_ptr_s = 2'd1;
      end
      3'b010: begin
        sel_addr_s = bus.req_addr1;
        sel_data_s = bus.req_data1;
        next_ptr_s = 2'd2;
      end
      3'b100: begin
        sel_addr_s = bus.req_addr2;
        sel_data_s = bus.req_data2;
        next_ptr_s = 2'd0;
      end
      default: begin
        sel_addr_s = ADDR_Z;
        sel_data_s = {DATA_W{1'b0}};
        next_ptr_s = rr_ptr_q;
      end
    endcase
  end

  // State register plus the sequencer, pointer and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q     <= ADDR_Z;
      rr_ptr_q  <= 2'd0;
      pending_q <= {NUM_REGS{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

  // Next-state: zero-fill walks all entries once, then stays in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    endcase
  end

  // Issue sets are dropped for the hard-wired zero register.
  always_comb begin
    if (bus.iss_valid && !(ZERO_REG && (bus.iss_addr == ADDR_Z))) begin
      iss_set_s = 1'b1;
    end else begin
      iss_set_s = 1'b0;
    end
  end

  // Pointer and scoreboard update; set is applied after clear so a new producer wins.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q;
    if (state_q == ST_RUN) begin
      if (grant_s != 3'b000) begin
        rr_ptr_d              = next_ptr_s;
        pending_d[sel_addr_s] = 1'b0;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      if (iss_set_s) begin
        pending_d[bus.iss_addr] = 1'b1;
      end else begin
        pending_d = pending_d;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // Output decode: reset blanks the port, INIT zero-fills, RUN forwards the winner.
  always_comb begin
    bus.req_ready = 3'b000;
    bus.rf_we     = 1'b0;
    bus.rf_wa     = ADDR_Z;
    bus.rf_wd     = {DATA_W{1'b0}};
    bus.init_busy = 1'b0;
    if (rst) begin
      bus.init_busy = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          bus.rf_we     = 1'b1;
          bus.rf_wa     = cnt_q;
          bus.init_busy = 1'b1;
        end
        ST_RUN: begin
          bus.req_ready = grant_s;
          if (grant_s != 3'b000) begin
            bus.rf_wa = sel_addr_s;
            bus.rf_wd = sel_data_s;
            bus.rf_we = !(ZERO_REG && (sel_addr_s == ADDR_Z));
          end else begin
            bus.rf_we = 1'b0;
          end
        end
        default: bus.init_busy = 1'b1;
      endcase
    end
  end

  // Scoreboard query reflects only committed state, no same-cycle bypass.
  assign bus.chk_busy = pending_q[bus.chk_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [31:0] ram [0:63];
  logic [2:0]  exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [5:0]  exp_a [4] = '{6'd5, 6'd6, 6'd7, 6'd5};
  logic [31:0] exp_d [4] = '{32'hA, 32'hB, 32'hC, 32'hA};
  logic [2:0]  fair_g [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(
    .ADDR_W(6), .DATA_W(32), .CLEAR_ON_RESET(1'b1), .ZERO_REG(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External register file: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (bus.rf_we === 1'b1) ram[bus.rf_wa] <= bus.rf_wd;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hFFFF_FFFF;
    bus.req_valid = 3'b111;
    bus.req_addr0 = 6'd1; bus.req_addr1 = 6'd2; bus.req_addr2 = 6'd3;
    bus.req_data0 = 32'h1; bus.req_data1 = 32'h2; bus.req_data2 = 32'h3;
    bus.iss_valid = 1'b0; bus.iss_addr = 6'd0; bus.chk_addr = 6'd0;
    rst = 1'b1;
    #1;
    check("reset_outputs", 64'({bus.req_ready, bus.rf_we, bus.rf_wa, bus.rf_wd, bus.init_busy}),
          64'({3'b000, 1'b0, 6'd0, 32'h0, 1'b1}));
    tick();
    tick();

    // Zero-fill after reset; issue requests are ignored meanwhile.
    rst = 1'b0;
    bus.req_valid = 3'b000;
    bus.iss_valid = 1'b1; bus.iss_addr = 6'd5; bus.chk_addr = 6'd5;
    #1;
    for (int i = 0; i < 64; i++) begin
      check("init_write", 64'({bus.rf_we, bus.rf_wa, bus.rf_wd, bus.init_busy, bus.req_ready, bus.chk_busy}),
            64'({1'b1, i[5:0], 32'h0, 1'b1, 3'b000, 1'b0}));
      tick();
    end
    bus.iss_valid = 1'b0;
    #1;
    check("run_idle", 64'({bus.init_busy, bus.rf_we, bus.req_ready}), 64'({1'b0, 1'b0, 3'b000}));
    check("init_iss_ignored", 64'(bus.chk_busy), 64'(1'b0));
    for (int i = 0; i < 64; i++) check("ram_cleared", 64'(ram[i]), 64'h0);

    // Three continuously valid requesters rotate one grant per cycle.
    bus.req_valid = 3'b111;
    bus.req_addr0 = 6'd5; bus.req_addr1 = 6'd6; bus.req_addr2 = 6'd7;
    bus.req_data0 = 32'hA; bus.req_data1 = 32'hB; bus.req_data2 = 32'hC;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_all_three", 64'({bus.req_ready, bus.rf_we, bus.rf_wa, bus.rf_wd}),
            64'({exp_g[k], 1'b1, exp_a[k], exp_d[k]}));
      tick();
    end
    bus.req_valid = 3'b000;
    #1;
    check("ram5", 64'(ram[5]), 64'hA);
    check("ram6", 64'(ram[6]), 64'hB);
    check("ram7", 64'(ram[7]), 64'hC);

    // Scoreboard round trip on register 12 (rr_ptr is 1 here).
    bus.chk_addr = 6'd12; bus.iss_valid = 1'b1; bus.iss_addr = 6'd12;
    #1;
    check("sb_no_bypass", 64'(bus.chk_busy), 64'(1'b0));
    tick();
    bus.iss_valid = 1'b0;
    bus.req_valid = 3'b010; bus.req_addr1 = 6'd12; bus.req_data1 = 32'h12;
    #1;
    check("sb_busy_after_issue", 64'({bus.chk_busy, bus.req_ready}), 64'({1'b1, 3'b010}));
    tick();
    bus.req_valid = 3'b000;
    #1;
    check("sb_cleared_by_wb", 64'(bus.chk_busy), 64'(1'b0));
    check("ram12", 64'(ram[12]), 64'h12);
    bus.iss_valid = 1'b1; bus.iss_addr = 6'd12;
    tick();
    bus.req_valid = 3'b010; bus.req_data1 = 32'h1212;
    #1;
    check("sb_reissue", 64'({bus.chk_busy, bus.req_ready}), 64'({1'b1, 3'b010}));
    tick();
    bus.req_valid = 3'b000; bus.iss_valid = 1'b0;
    #1;
    check("sb_set_wins", 64'(bus.chk_busy), 64'(1'b1));
    bus.iss_valid = 1'b1; bus.iss_addr = 6'd13;
    bus.req_valid = 3'b010; bus.req_data1 = 32'h3;
    tick();
    bus.iss_valid = 1'b0; bus.req_valid = 3'b000;
    #1;
    check("sb_diff_clear", 64'(bus.chk_busy), 64'(1'b0));
    bus.chk_addr = 6'd13;
    #1;
    check("sb_diff_set", 64'(bus.chk_busy), 64'(1'b1));

    // Writeback to a non-pending register (rr_ptr is 2, ALU alone wins).
    bus.chk_addr = 6'd40;
    bus.req_valid = 3'b001; bus.req_addr0 = 6'd40; bus.req_data0 = 32'h40;
    #1;
    check("nonpending_grant", 64'({bus.req_ready, bus.rf_we, bus.rf_wa}), 64'({3'b001, 1'b1, 6'd40}));
    tick();
    bus.req_valid = 3'b000;
    #1;
    check("nonpending_busy", 64'(bus.chk_busy), 64'(1'b0));
    check("ram40", 64'(ram[40]), 64'h40);

    // Zero register: load write to r0 is granted but suppressed.
    bus.req_valid = 3'b100; bus.req_addr2 = 6'd0; bus.req_data2 = 32'hDEAD_BEEF;
    #1;
    check("zero_reg_grant", 64'({bus.req_ready, bus.rf_we}), 64'({3'b100, 1'b0}));
    tick();
    bus.req_valid = 3'b000;
    bus.iss_valid = 1'b1; bus.iss_addr = 6'd0; bus.chk_addr = 6'd0;
    tick();
    bus.iss_valid = 1'b0;
    #1;
    check("zero_reg_not_pending", 64'(bus.chk_busy), 64'(1'b0));
    check("ram0_kept", 64'(ram[0]), 64'h0);

    // Fairness with FPU and load only, rr_ptr back at 0.
    bus.req_valid = 3'b110;
    bus.req_addr1 = 6'd21; bus.req_addr2 = 6'd22;
    bus.req_data1 = 32'h21; bus.req_data2 = 32'h22;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("fair_two", 64'(bus.req_ready), 64'(fair_g[k]));
      tick();
    end
    bus.req_valid = 3'b000;

    // Reset in RUN with pending bits set and rr_ptr moved away from 0.
    bus.iss_valid = 1'b1; bus.iss_addr = 6'd3;
    bus.req_valid = 3'b010; bus.req_addr1 = 6'd23;
    tick();
    bus.req_valid = 3'b000; bus.iss_addr = 6'd9;
    tick();
    bus.iss_valid = 1'b0; bus.chk_addr = 6'd3;
    #1;
    check("pend3_set", 64'(bus.chk_busy), 64'(1'b1));
    bus.chk_addr = 6'd9;
    #1;
    check("pend9_set", 64'(bus.chk_busy), 64'(1'b1));
    bus.req_valid = 3'b111;
    bus.req_addr0 = 6'd33; bus.req_data0 = 32'h33;
    rst = 1'b1;
    #1;
    check("midrun_reset", 64'({bus.req_ready, bus.rf_we, bus.rf_wa, bus.rf_wd, bus.init_busy}),
          64'({3'b000, 1'b0, 6'd0, 32'h0, 1'b1}));
    tick();
    rst = 1'b0; bus.chk_addr = 6'd3;
    #1;
    for (int i = 0; i < 64; i++) begin
      check("reinit_write", 64'({bus.rf_we, bus.rf_wa, bus.rf_wd, bus.init_busy, bus.req_ready, bus.chk_busy}),
            64'({1'b1, i[5:0], 32'h0, 1'b1, 3'b000, 1'b0}));
      tick();
    end
    bus.chk_addr = 6'd9;
    #1;
    check("pend9_cleared", 64'(bus.chk_busy), 64'(1'b0));
    check("first_grant_alu", 64'({bus.req_ready, bus.rf_we, bus.rf_wa, bus.rf_wd}),
          64'({3'b001, 1'b1, 6'd33, 32'h33}));
    bus.req_valid = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
